// File: rtl/axis_demux_router.sv
// 1-to-N AXI-Stream packet demultiplexer: routes each packet to the master port named on its first beat.
// Optional AXIS_DEMUX_DROP_CNT_EN adds a saturating 16-bit count of discarded (out-of-range) packets.
module axis_demux_router #(
    parameter int          N_PORTS      = 4,
    parameter int          T_DATA_WIDTH = 8,
    parameter int          T_DEST_WIDTH = 8,
    parameter int          T_ID_WIDTH   = 8,
    parameter logic [T_ID_WIDTH-1:0] SRC_ID = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [T_DEST_WIDTH-1:0]          s_dest,
    input  logic [T_DATA_WIDTH-1:0]          s_data,
    input  logic                             s_last,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [N_PORTS*T_ID_WIDTH-1:0]    m_id,
    output logic [N_PORTS*T_DATA_WIDTH-1:0]  m_data,
    output logic [N_PORTS-1:0]               m_last,
    output logic [N_PORTS-1:0]               m_valid,
    input  logic [N_PORTS-1:0]               m_ready
`ifdef AXIS_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]                      drop_cnt
`endif
);

    localparam int SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                  state_q, state_d;
    logic                    bufVld_q, bufVld_d;
    logic                    bufLast_q, bufLast_d;
    logic [SEL_W-1:0]        bufSel_q, bufSel_d;
    logic [T_DATA_WIDTH-1:0] bufData_q, bufData_d;

    logic        free;
    logic        handshake;
    logic        destOk;
    logic [31:0] destExt;

    assign destExt   = 32'(s_dest);
    assign destOk    = destExt < 32'(N_PORTS);
    assign free      = !bufVld_q || m_ready[bufSel_q];
    // Discarding never needs the buffer, so DROP accepts regardless of downstream ready.
    assign s_ready   = !reset && ((state_q == DROP) ? 1'b1 : free);
    assign handshake = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bufVld_q  <= 1'b0;
            bufLast_q <= 1'b0;
            bufSel_q  <= '0;
            bufData_q <= '0;
        end else begin
            state_q   <= state_d;
            bufVld_q  <= bufVld_d;
            bufLast_q <= bufLast_d;
            bufSel_q  <= bufSel_d;
            bufData_q <= bufData_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bufVld_d  = bufVld_q;
        bufLast_d = bufLast_q;
        bufSel_d  = bufSel_q;
        bufData_d = bufData_q;

        if (bufVld_q && m_ready[bufSel_q]) begin
            bufVld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (destOk) begin
                        bufVld_d  = 1'b1;
                        bufData_d = s_data;
                        bufLast_d = s_last;
                        bufSel_d  = s_dest[SEL_W-1:0];
                        state_d   = s_last ? IDLE : ROUTE;
                    end else begin
                        state_d   = s_last ? IDLE : DROP;
                    end
                end
            end
            ROUTE: begin
                if (handshake) begin
                    bufVld_d  = 1'b1;
                    bufData_d = s_data;
                    bufLast_d = s_last;
                    if (s_last) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (handshake && s_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : gLane
        assign m_valid[i]                               = bufVld_q && (bufSel_q == SEL_W'(i));
        assign m_last[i]                                = bufLast_q;
        assign m_data[i*T_DATA_WIDTH +: T_DATA_WIDTH]   = bufData_q;
        assign m_id[i*T_ID_WIDTH +: T_ID_WIDTH]         = SRC_ID;
    end

`ifdef AXIS_DEMUX_DROP_CNT_EN
    logic [15:0] dropCnt_q;
    logic        firstDrop;

    assign firstDrop = (state_q == IDLE) && handshake && !destOk;
    assign drop_cnt  = dropCnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dropCnt_q <= '0;
        end else if (firstDrop && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_q <= dropCnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_demux_router.sv
// Scoreboard bench for axis_demux_router: a model of accepted beats is queued at the input
// and matched against every beat leaving a master lane.
module tb_axis_demux_router;

    localparam int NP    = 4;
    localparam int DW    = 8;
    localparam int DESTW = 8;
    localparam int IDW   = 8;
    localparam logic [IDW-1:0] SRCID = 8'h5A;

    logic               clk = 1'b0;
    logic               reset;
    logic [DESTW-1:0]   s_dest;
    logic [DW-1:0]      s_data;
    logic               s_last;
    logic               s_valid;
    logic               s_ready;
    logic [NP*IDW-1:0]  m_id;
    logic [NP*DW-1:0]   m_data;
    logic [NP-1:0]      m_last;
    logic [NP-1:0]      m_valid;
    logic [NP-1:0]      m_ready;
`ifdef AXIS_DEMUX_DROP_CNT_EN
    logic [15:0]        drop_cnt;
`endif

    axis_demux_router #(
        .N_PORTS(NP), .T_DATA_WIDTH(DW), .T_DEST_WIDTH(DESTW), .T_ID_WIDTH(IDW), .SRC_ID(SRCID)
    ) dut (
        .clk(clk), .reset(reset),
        .s_dest(s_dest), .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_id(m_id), .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
`ifdef AXIS_DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [7:0] data;
        logic       last;
        int         acc;
    } beat_t;

    beat_t expQ[$];
    int    hsQ[$];
    int    vecCount  = 0;
    int    missCount = 0;
    int    cyc       = 0;
    bit    chkLat    = 0;
    bit    chkReady  = 0;
    bit    bpMode    = 0;
    int    bpIdx     = 0;
    bit    tbInPkt   = 0;
    int    tbDest    = 0;
    int    expDrop   = 0;
    bit    holdValid = 0;
    int    holdPort  = 0;
    logic [7:0] holdData;
    logic       holdLast;

    always @(posedge clk) cyc++;

    // Backpressure pattern on port 1: ready 1,0,0 repeating, changed just after each edge.
    always @(posedge clk) begin
        #1;
        if (bpMode) begin
            bpIdx = (bpIdx + 1) % 3;
            m_ready[1] = (bpIdx == 0);
        end
    end

    // Output monitor: checks each transferring beat against the scoreboard and held beats for stability.
    always @(negedge clk) begin
        if (reset) begin
            holdValid = 0;
        end else begin
            if (m_valid != '0) begin
                vecCount++;
                if ($countones(m_valid) != 1) begin
                    missCount++;
                    $display("[TB] FAIL onehot: m_valid=%b required at most one lane", m_valid);
                end
            end
            if (holdValid) begin
                vecCount++;
                if (m_valid[holdPort] !== 1'b1 || m_data[holdPort*DW +: DW] !== holdData ||
                    m_last[holdPort] !== holdLast) begin
                    missCount++;
                    $display("[TB] FAIL stable: lane %0d valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             holdPort, m_valid[holdPort], m_data[holdPort*DW +: DW], m_last[holdPort], holdData, holdLast);
                end
            end
            holdValid = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_valid[i] === 1'b1) begin
                    if (m_ready[i] === 1'b1) begin
                        vecCount++;
                        if (expQ.size() == 0) begin
                            missCount++;
                            $display("[TB] FAIL unexpected: lane %0d data=%h required no beat", i, m_data[i*DW +: DW]);
                        end else begin
                            beat_t e;
                            e = expQ.pop_front();
                            if (i != e.port || m_data[i*DW +: DW] !== e.data || m_last[i] !== e.last ||
                                m_id[i*IDW +: IDW] !== SRCID || (chkLat && cyc != e.acc + 1)) begin
                                missCount++;
                                $display("[TB] FAIL beat: lane %0d data=%h last=%b id=%h cyc=%0d required lane %0d data=%h last=%b id=%h cyc=%0d",
                                         i, m_data[i*DW +: DW], m_last[i], m_id[i*IDW +: IDW], cyc,
                                         e.port, e.data, e.last, SRCID, e.acc + 1);
                            end
                        end
                    end else begin
                        holdValid = 1;
                        holdPort  = i;
                        holdData  = m_data[i*DW +: DW];
                        holdLast  = m_last[i];
                    end
                end
            end
            if (chkReady) begin
                logic expReady;
                expReady = (m_valid == '0) || ((m_valid & m_ready) != '0);
                vecCount++;
                if (s_ready !== expReady) begin
                    missCount++;
                    $display("[TB] FAIL s_ready_free: s_ready=%b required %b", s_ready, expReady);
                end
            end
        end
    end

    // Drives one beat and waits for its handshake; the model decides where the beat should exit.
    task automatic sendBeat(input logic [7:0] dest, input logic [7:0] data, input logic last, output int waits);
        bit done = 0;
        waits = 0;
        s_valid = 1'b1;
        s_dest  = dest;
        s_data  = data;
        s_last  = last;
        while (!done) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                beat_t e;
                hsQ.push_back(cyc);
                if (!tbInPkt) begin
                    tbDest = int'(dest);
                    if (tbDest >= NP) expDrop++;
                end
                if (tbDest < NP) begin
                    e.port = tbDest; e.data = data; e.last = last; e.acc = cyc;
                    expQ.push_back(e);
                end
                tbInPkt = !last;
                done = 1;
            end else begin
                waits++;
                if (waits > 200) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL handshake_timeout: s_ready=%b required 1 within 200 cycles", s_ready);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL %s_drain: %0d beats outstanding required 0", name, expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_dest = '0; s_data = '0; m_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecCount++;
        if (m_valid !== '0 || s_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_hold: m_valid=%b s_ready=%b required 0000 0", m_valid, s_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vecCount++;
        if (m_valid !== '0 || s_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_release: m_valid=%b s_ready=%b required 0000 1", m_valid, s_ready);
        end
`ifdef AXIS_DEMUX_DROP_CNT_EN
        vecCount++;
        if (drop_cnt !== 16'd0) begin
            missCount++;
            $display("[TB] FAIL reset_dropcnt: drop_cnt=%0d required 0", drop_cnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int w;
        chkLat = 1;
        sendBeat(8'd2, 8'h11, 1'b0, w);
        sendBeat(8'd2, 8'h22, 1'b0, w);
        sendBeat(8'd2, 8'h33, 1'b1, w);
        idleIn();
        waitDrain("single");
        chkLat = 0;
    endtask

    task automatic test_backpressure();
        int w;
        bpIdx = 0; m_ready[1] = 1'b1; bpMode = 1; chkReady = 1;
        sendBeat(8'd1, 8'h41, 1'b0, w);
        sendBeat(8'd1, 8'h42, 1'b0, w);
        sendBeat(8'd1, 8'h43, 1'b0, w);
        sendBeat(8'd1, 8'h44, 1'b1, w);
        idleIn();
        waitDrain("backpressure");
        bpMode = 0; chkReady = 0;
        m_ready = '1;
    endtask

    task automatic test_dest_change();
        int w;
        sendBeat(8'd0, 8'h51, 1'b0, w);
        sendBeat(8'd3, 8'h52, 1'b0, w);
        sendBeat(8'd3, 8'h53, 1'b1, w);
        idleIn();
        waitDrain("dest_change");
    endtask

    task automatic test_back_to_back();
        int w;
        hsQ.delete();
        sendBeat(8'd3, 8'h61, 1'b1, w);
        sendBeat(8'd0, 8'h62, 1'b0, w);
        sendBeat(8'd0, 8'h63, 1'b1, w);
        idleIn();
        vecCount++;
        if (hsQ.size() != 3 || hsQ[1] != hsQ[0] + 1 || hsQ[2] != hsQ[1] + 1) begin
            missCount++;
            $display("[TB] FAIL back_to_back_gap: %0d handshakes first=%0d last=%0d required 3 consecutive",
                     hsQ.size(), hsQ[0], hsQ[hsQ.size()-1]);
        end
        waitDrain("back_to_back");
    endtask

    task automatic test_invalid_dest();
        int w;
        int totalWaits = 0;
        for (int b = 0; b < 5; b++) begin
            sendBeat(8'd7, 8'h70 + 8'(b), (b == 4), w);
            totalWaits += w;
        end
        idleIn();
        vecCount++;
        if (totalWaits != 0) begin
            missCount++;
            $display("[TB] FAIL drop_ready: %0d stalled cycles required 0", totalWaits);
        end
        @(negedge clk);
        vecCount++;
        if (m_valid !== '0) begin
            missCount++;
            $display("[TB] FAIL drop_quiet: m_valid=%b required 0000", m_valid);
        end
        @(posedge clk);
        #1;
        sendBeat(8'd1, 8'h81, 1'b0, w);
        sendBeat(8'd1, 8'h82, 1'b1, w);
        idleIn();
        waitDrain("after_drop");
`ifdef AXIS_DEMUX_DROP_CNT_EN
        vecCount++;
        if (drop_cnt !== 16'(expDrop)) begin
            missCount++;
            $display("[TB] FAIL drop_cnt: drop_cnt=%0d required %0d", drop_cnt, expDrop);
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        int w;
        sendBeat(8'd2, 8'hA1, 1'b0, w);
        sendBeat(8'd2, 8'hA2, 1'b0, w);
        idleIn();
        reset = 1'b1;
        @(negedge clk);
        vecCount++;
        if (s_ready !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_cycle_ready: s_ready=%b required 0", s_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        tbInPkt = 0;
        @(negedge clk);
        vecCount++;
        if (m_valid !== '0 || s_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_mid_state: m_valid=%b s_ready=%b required 0000 1", m_valid, s_ready);
        end
        @(posedge clk);
        #1;
        sendBeat(8'd0, 8'h99, 1'b1, w);
        idleIn();
        waitDrain("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_dest_change();
        test_back_to_back();
        test_invalid_dest();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
